sync_fifo: RTL and testbench

//  Single-clock FIFO with internal RAM; parametrised successor to the write-port/read-port FIFO memory.

---
 rtl/sync_fifo.sv | 98 +++++++++
 tb/tb_sync_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read, occupancy count,
// threshold flags and sticky overflow/underflow error flags.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 8,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int AF_LEVEL   = MEM_DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  FLUSH,
    input  logic                  W_EN,
    input  logic [DATA_WIDTH-1:0] W_DATA,
    input  logic                  R_EN,
    output logic [DATA_WIDTH-1:0] R_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = MEM_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  ovf_nxt;
    logic                  udf_nxt;

    // Accept decisions, next occupancy and next sticky error state.
    always_comb begin
        push_ok   = W_EN & (~FULL | R_EN);
        pop_ok    = R_EN & ~EMPTY;
        count_nxt = COUNT;
        ovf_nxt   = OVERFLOW | (W_EN & ~push_ok);
        udf_nxt   = UNDERFLOW | (R_EN & EMPTY);
        if (FLUSH) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            udf_nxt   = 1'b0;
        end else if (push_ok & ~pop_ok) begin
            count_nxt = COUNT + 1'b1;
        end else if (pop_ok & ~push_ok) begin
            count_nxt = COUNT - 1'b1;
        end
    end

    // Pointers, count and flags; flags come from next count so they never lag.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            COUNT        <= '0;
            FULL         <= 1'b0;
            EMPTY        <= 1'b1;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
        end else begin
            if (FLUSH) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            end
            COUNT        <= count_nxt;
            FULL         <= (count_nxt == DEPTH_C);
            EMPTY        <= (count_nxt == '0);
            ALMOST_FULL  <= (count_nxt >= AF_C);
            ALMOST_EMPTY <= (count_nxt <= AE_C);
            OVERFLOW     <= ovf_nxt;
            UNDERFLOW    <= udf_nxt;
        end
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge CLK) begin
        if (!FLUSH && push_ok) mem[wr_ptr] <= W_DATA;
    end

    // Show-ahead head word, forced to zero while empty.
    always_comb begin
        R_DATA = '0;
        if (!EMPTY) R_DATA = mem[rd_ptr];
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: scoreboard queue of pushed words,
// per-scenario tasks with inline comparisons.
module tb_sync_fifo;

    localparam int DEPTH = 8;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       FLUSH = 1'b0;
    logic       W_EN = 1'b0;
    logic [7:0] W_DATA = 8'h00;
    logic       R_EN = 1'b0;
    logic [7:0] R_DATA;
    logic       FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
    logic [3:0] COUNT;
    logic       OVERFLOW, UNDERFLOW;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];
    bit m_ovf = 0;
    bit m_udf = 0;

    sync_fifo dut (
        .CLK(CLK), .RST_n(RST_n), .FLUSH(FLUSH),
        .W_EN(W_EN), .W_DATA(W_DATA), .R_EN(R_EN),
        .R_DATA(R_DATA), .FULL(FULL), .EMPTY(EMPTY),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
        .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    // One clock of stimulus; popped words are checked against the scoreboard.
    task automatic step(input logic w, input logic [7:0] wd, input logic r);
        logic [7:0] exp_rd;
        bit push_ok, pop_ok;
        exp_rd = (q.size() > 0) ? q[0] : 8'h00;
        if (r) begin
            checks++;
            if (R_DATA !== exp_rd) begin
                errors++;
                $display("FAIL pop_data: got %h want %h", R_DATA, exp_rd);
            end
        end
        push_ok = w && (q.size() < DEPTH || r);
        pop_ok  = r && (q.size() > 0);
        if (w && !push_ok) m_ovf = 1;
        if (r && q.size() == 0) m_udf = 1;
        W_EN = w; W_DATA = wd; R_EN = r;
        @(posedge CLK); #1;
        W_EN = 0; R_EN = 0;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(wd);
    endtask

    task automatic do_flush(input logic w, input logic [7:0] wd);
        FLUSH = 1; W_EN = w; W_DATA = wd;
        @(posedge CLK); #1;
        FLUSH = 0; W_EN = 0;
        q.delete(); m_ovf = 0; m_udf = 0;
    endtask

    task automatic test_reset();
        RST_n = 0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 110000",
                {EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW});
        end
        checks++;
        if (COUNT !== 4'd0 || R_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_cnt_data: got %0d/%h want 0/00", COUNT, R_DATA);
        end
        RST_n = 1;
        @(posedge CLK); #1;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 8'(8'h11 * i), 0);
            checks++;
            if (COUNT !== 4'(i) || EMPTY !== 1'b0 || FULL !== (i == DEPTH)
                || ALMOST_FULL !== (i >= 6) || ALMOST_EMPTY !== (i <= 2)) begin
                errors++;
                $display("FAIL fill_flags[%0d]: got cnt=%0d e=%b f=%b af=%b ae=%b", i,
                    COUNT, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY);
            end
        end
        step(1, 8'h99, 0);
        checks++;
        if (OVERFLOW !== 1'b1 || COUNT !== 4'd8 || FULL !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got ovf=%b cnt=%0d want 1/8", OVERFLOW, COUNT);
        end
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);
        checks++;
        if (EMPTY !== 1'b1 || COUNT !== 4'd0 || UNDERFLOW !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL drain: got e=%b cnt=%0d udf=%b want 1/0/0", EMPTY, COUNT, UNDERFLOW);
        end
    endtask

    task automatic test_wrap();
        do_flush(0, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1);
        for (int i = 0; i < 6; i++) step(1, 8'(8'hA0 + i), 0);
        checks++;
        if (COUNT !== 4'd6 || R_DATA !== 8'hA0) begin
            errors++;
            $display("FAIL wrap_mid: got cnt=%0d rd=%h want 6/a0", COUNT, R_DATA);
        end
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1);
        checks++;
        if (COUNT !== 4'd0 || EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL wrap_end: got cnt=%0d e=%b want 0/1", COUNT, EMPTY);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= DEPTH; i++) step(1, 8'(8'h11 * i), 0);
        step(1, 8'hEE, 1);
        checks++;
        if (COUNT !== 4'd8 || FULL !== 1'b1 || R_DATA !== 8'h22 || OVERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL full_rw: got cnt=%0d f=%b rd=%h ovf=%b want 8/1/22/0",
                COUNT, FULL, R_DATA, OVERFLOW);
        end
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);
        checks++;
        if (EMPTY !== 1'b1 || UNDERFLOW !== 1'b0) begin
            errors++;
            $display("FAIL full_rw_drain: got e=%b udf=%b want 1/0", EMPTY, UNDERFLOW);
        end
        step(1, 8'h5A, 1);
        checks++;
        if (COUNT !== 4'd1 || R_DATA !== 8'h5A || UNDERFLOW !== 1'b1 || EMPTY !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw: got cnt=%0d rd=%h udf=%b want 1/5a/1", COUNT, R_DATA, UNDERFLOW);
        end
        step(0, 8'h00, 1);
        checks++;
        if (UNDERFLOW !== 1'(m_udf) || EMPTY !== 1'b1) begin
            errors++;
            $display("FAIL udf_sticky: got udf=%b want %b", UNDERFLOW, m_udf);
        end
    endtask

    task automatic test_flush();
        do_flush(0, 8'h00);
        for (int i = 0; i < 9; i++) step(1, 8'(8'hC0 + i), 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        checks++;
        if (COUNT !== 4'd4 || OVERFLOW !== 1'(m_ovf)) begin
            errors++;
            $display("FAIL pre_flush: got cnt=%0d ovf=%b want 4/%b", COUNT, OVERFLOW, m_ovf);
        end
        do_flush(1, 8'hFF);
        checks++;
        if (COUNT !== 4'd0 || EMPTY !== 1'b1 || OVERFLOW !== 1'b0 || ALMOST_EMPTY !== 1'b1
            || R_DATA !== 8'h00) begin
            errors++;
            $display("FAIL flush: got cnt=%0d e=%b ovf=%b rd=%h want 0/1/0/00",
                COUNT, EMPTY, OVERFLOW, R_DATA);
        end
        step(1, 8'h3C, 0);
        checks++;
        if (R_DATA !== 8'h3C || COUNT !== 4'd1) begin
            errors++;
            $display("FAIL post_flush: got rd=%h cnt=%0d want 3c/1", R_DATA, COUNT);
        end
        step(0, 8'h00, 1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0);
        checks++;
        if (COUNT !== 4'd5) begin
            errors++;
            $display("FAIL pre_rst: got cnt=%0d want 5", COUNT);
        end
        #2 RST_n = 0;
        #1;
        checks++;
        if (COUNT !== 4'd0 || EMPTY !== 1'b1 || R_DATA !== 8'h00) begin
            errors++;
            $display("FAIL async_rst: got cnt=%0d e=%b rd=%h want 0/1/00", COUNT, EMPTY, R_DATA);
        end
        q.delete(); m_ovf = 0; m_udf = 0;
        @(posedge CLK); #3 RST_n = 1;
        @(posedge CLK); #1;
        step(1, 8'h77, 0);
        checks++;
        if (R_DATA !== 8'h77 || COUNT !== 4'd1) begin
            errors++;
            $display("FAIL rst_push: got rd=%h cnt=%0d want 77/1", R_DATA, COUNT);
        end
        step(0, 8'h00, 1);
        checks++;
        if (EMPTY !== 1'b1 || COUNT !== 4'd0) begin
            errors++;
            $display("FAIL rst_pop: got e=%b cnt=%0d want 1/0", EMPTY, COUNT);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
